q_response_checker: RTL and testbench

- Hardware response checker for the Q mapping (4-bit x -> 2-bit Qx); the receiving and judging end of the sweep that drives all 16 x values through Q.
- Accepts x/Qx pairs over a valid/ready stream and compares each Qx against a loaded 16-entry expected table.
- Counts mismatches, records the first failure, tracks input coverage, and produces a single pass/done verdict for on-chip self-test.

---
 rtl/q_chk_pkg.sv | 15 +
 rtl/q_expect_table.sv | 28 ++
 rtl/q_response_checker.sv | 100 ++++++++++
 tb/tb_q_response_checker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/q_chk_pkg.sv
// Shared constants and state encoding for the Q-mapping response checker.
package q_chk_pkg;

    localparam int X_W   = 4;
    localparam int Q_W   = 2;
    localparam int N_VEC = 16;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/q_expect_table.sv
// Expected-Qx register file: one entry per x value.
// Synchronous write, combinational read, asynchronous clear.
module q_expect_table
    import q_chk_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [X_W-1:0]   waddr,
    input  logic [Q_W-1:0]   wdata,
    input  logic [X_W-1:0]   raddr,
    output logic [Q_W-1:0]   rdata
);

    logic [Q_W-1:0] mem [N_VEC];

    // NOTE: the table must clear on reset, so it is built from flops, not a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_VEC; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/q_response_checker.sv
// Judges a 16-vector sweep of x/Qx pairs against a loaded expected table and
// produces error count, first-failure capture, coverage and a pass verdict.
module q_response_checker
    import q_chk_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              exp_we,
    input  logic [X_W-1:0]    exp_addr,
    input  logic [Q_W-1:0]    exp_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [X_W-1:0]    in_x,
    input  logic [Q_W-1:0]    in_qx,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [X_W-1:0]    first_err_x,
    output logic [Q_W-1:0]    first_err_got,
    output logic [Q_W-1:0]    first_err_exp,
    output logic              dup_flag,
    output logic [N_VEC-1:0]  seen_mask
);

    state_t          state;
    logic [CNT_W-1:0] vec_count;
    logic [Q_W-1:0]  exp_qx;
    logic            xfer;
    logic            mismatch;
    logic            last_xfer;

    q_expect_table u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (exp_we && (state == IDLE)),
        .waddr (exp_addr),
        .wdata (exp_data),
        .raddr (in_x),
        .rdata (exp_qx)
    );

    assign xfer      = in_valid && in_ready;
    assign mismatch  = (in_qx != exp_qx);
    assign last_xfer = (vec_count == CNT_W'(N_VEC - 1));

    // NOTE: all state below is sequential and uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            vec_count     <= '0;
            err_count     <= '0;
            seen_mask     <= '0;
            dup_flag      <= 1'b0;
            first_err_x   <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= RUN;
                        vec_count     <= '0;
                        err_count     <= '0;
                        seen_mask     <= '0;
                        dup_flag      <= 1'b0;
                        first_err_x   <= '0;
                        first_err_got <= '0;
                        first_err_exp <= '0;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        vec_count       <= vec_count + 1'b1;
                        seen_mask[in_x] <= 1'b1;
                        if (seen_mask[in_x]) dup_flag <= 1'b1;
                        if (mismatch) begin
                            if (err_count != '1) err_count <= err_count + 1'b1;
                            // Capture only the run's first mismatch.
                            if (err_count == '0) begin
                                first_err_x   <= in_x;
                                first_err_got <= in_qx;
                                first_err_exp <= exp_qx;
                            end
                        end
                        if (last_xfer) state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign in_ready = busy;
    assign pass     = done && (err_count == '0) && !dup_flag && (&seen_mask);

endmodule

// File: tb/tb_q_response_checker.sv
// Self-checking bench for q_response_checker: table-driven runs with a
// per-transfer scoreboard plus hand-written restart, ignore and reset sequences.
module tb_q_response_checker;
    import q_chk_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              exp_we;
    logic [X_W-1:0]    exp_addr;
    logic [Q_W-1:0]    exp_data;
    logic              in_valid;
    logic              in_ready;
    logic [X_W-1:0]    in_x;
    logic [Q_W-1:0]    in_qx;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  err_count;
    logic [X_W-1:0]    first_err_x;
    logic [Q_W-1:0]    first_err_got;
    logic [Q_W-1:0]    first_err_exp;
    logic              dup_flag;
    logic [N_VEC-1:0]  seen_mask;

    q_response_checker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .exp_we        (exp_we),
        .exp_addr      (exp_addr),
        .exp_data      (exp_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_x          (in_x),
        .in_qx         (in_qx),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_x   (first_err_x),
        .first_err_got (first_err_got),
        .first_err_exp (first_err_exp),
        .dup_flag      (dup_flag),
        .seen_mask     (seen_mask)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [Q_W-1:0]   mtable [N_VEC];
    logic [CNT_W-1:0] m_err;
    logic [N_VEC-1:0] m_seen;
    logic             m_dup;
    logic [X_W-1:0]   m_fx;
    logic [Q_W-1:0]   m_fg;
    logic [Q_W-1:0]   m_fe;
    int               m_cnt;

    typedef struct {
        logic [CNT_W-1:0] err;
        logic [N_VEC-1:0] seen;
        logic             dup;
        logic             busy;
        logic             done;
    } snap_t;

    snap_t sb_q[$];

    typedef struct {
        string            name;
        logic             do_dup;
        logic [X_W-1:0]   dup_x;
        logic [X_W-1:0]   omit_x;
        logic             do_bad;
        logic [X_W-1:0]   bad1;
        logic [X_W-1:0]   bad2;
        logic             exp_pass;
        logic [CNT_W-1:0] exp_err;
        logic [N_VEC-1:0] exp_seen;
        logic             exp_dup;
        logic [X_W-1:0]   exp_fx;
        logic [Q_W-1:0]   exp_fg;
        logic [Q_W-1:0]   exp_fe;
    } vec_t;

    function automatic logic [Q_W-1:0] fq(input logic [X_W-1:0] x);
        return x[1:0] ^ x[3:2];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear_run();
        m_err  = '0;
        m_seen = '0;
        m_dup  = 1'b0;
        m_fx   = '0;
        m_fg   = '0;
        m_fe   = '0;
        m_cnt  = 0;
    endtask

    task automatic load_table();
        for (int x = 0; x < N_VEC; x++) begin
            @(negedge clk);
            exp_we   = 1'b1;
            exp_addr = X_W'(x);
            exp_data = fq(X_W'(x));
            mtable[x] = fq(X_W'(x));
            @(posedge clk);
            #1 exp_we = 1'b0;
        end
    endtask

    task automatic do_start(input string name);
        @(negedge clk);
        start = 1'b1;
        model_clear_run();
        @(posedge clk);
        #1 start = 1'b0;
        check({name, " busy"},  32'(busy), 32'd1);
        check({name, " done"},  32'(done), 32'd0);
        check({name, " err"},   32'(err_count), 32'd0);
        check({name, " seen"},  32'(seen_mask), 32'd0);
    endtask

    // One transfer; optionally pulses exp_we/start alongside to show they are ignored in RUN.
    task automatic xfer(input logic [X_W-1:0] x, input logic [Q_W-1:0] q, input logic pulse);
        snap_t s;
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = x;
        in_qx    = q;
        exp_we   = pulse;
        exp_addr = 4'd2;
        exp_data = 2'b11;
        start    = pulse;
        if (q != mtable[x]) begin
            if (m_err == '0) begin
                m_fx = x;
                m_fg = q;
                m_fe = mtable[x];
            end
            if (m_err != '1) m_err = m_err + 1'b1;
        end
        if (m_seen[x]) m_dup = 1'b1;
        m_seen[x] = 1'b1;
        m_cnt++;
        s.err  = m_err;
        s.seen = m_seen;
        s.dup  = m_dup;
        s.busy = (m_cnt < N_VEC);
        s.done = (m_cnt == N_VEC);
        sb_q.push_back(s);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_we   = 1'b0;
        start    = 1'b0;
        s = sb_q.pop_front();
        check("xfer err_count", 32'(err_count), 32'(s.err));
        check("xfer seen_mask", 32'(seen_mask), 32'(s.seen));
        check("xfer dup_flag",  32'(dup_flag),  32'(s.dup));
        check("xfer busy",      32'(busy),      32'(s.busy));
        check("xfer done",      32'(done),      32'(s.done));
    endtask

    task automatic final_check(input vec_t v);
        check({v.name, " done"},     32'(done),          32'd1);
        check({v.name, " busy"},     32'(busy),          32'd0);
        check({v.name, " in_ready"}, 32'(in_ready),      32'd0);
        check({v.name, " pass"},     32'(pass),          32'(v.exp_pass));
        check({v.name, " err"},      32'(err_count),     32'(v.exp_err));
        check({v.name, " seen"},     32'(seen_mask),     32'(v.exp_seen));
        check({v.name, " dup"},      32'(dup_flag),      32'(v.exp_dup));
        check({v.name, " fx"},       32'(first_err_x),   32'(v.exp_fx));
        check({v.name, " fgot"},     32'(first_err_got), 32'(v.exp_fg));
        check({v.name, " fexp"},     32'(first_err_exp), 32'(v.exp_fe));
    endtask

    task automatic check_all_zero(input string name);
        check({name, " busy"},     32'(busy),          32'd0);
        check({name, " done"},     32'(done),          32'd0);
        check({name, " pass"},     32'(pass),          32'd0);
        check({name, " in_ready"}, 32'(in_ready),      32'd0);
        check({name, " err"},      32'(err_count),     32'd0);
        check({name, " seen"},     32'(seen_mask),     32'd0);
        check({name, " dup"},      32'(dup_flag),      32'd0);
        check({name, " fx"},       32'(first_err_x),   32'd0);
        check({name, " fgot"},     32'(first_err_got), 32'd0);
        check({name, " fexp"},     32'(first_err_exp), 32'd0);
    endtask

    vec_t vecs [3];
    vec_t v;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        in_valid = 1'b0;
        in_x     = '0;
        in_qx    = '0;
        for (int i = 0; i < N_VEC; i++) mtable[i] = '0;
        model_clear_run();

        // x=5 expects 2'b00 under this table; the bad run inverts Qx at x=5 and x=9.
        vecs[0] = '{"clean", 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0,
                    1'b1, 5'd0, 16'hFFFF, 1'b0, 4'd0, 2'b00, 2'b00};
        vecs[1] = '{"dup",   1'b1, 4'd3, 4'd12, 1'b0, 4'd0, 4'd0,
                    1'b0, 5'd0, 16'hEFFF, 1'b1, 4'd0, 2'b00, 2'b00};
        vecs[2] = '{"bad",   1'b0, 4'd0, 4'd0, 1'b1, 4'd5, 4'd9,
                    1'b0, 5'd2, 16'hFFFF, 1'b0, 4'd5, 2'b11, 2'b00};

        #1 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        load_table();

        for (int r = 0; r < 3; r++) begin
            do_start(vecs[r].name);
            for (int i = 0; i < N_VEC; i++) begin
                logic [X_W-1:0] x;
                logic [Q_W-1:0] q;
                x = X_W'(i);
                if (vecs[r].do_dup && x == vecs[r].omit_x) x = vecs[r].dup_x;
                q = fq(x);
                if (vecs[r].do_bad && (x == vecs[r].bad1 || x == vecs[r].bad2)) q = q ^ 2'b11;
                xfer(x, q, 1'b0);
            end
            final_check(vecs[r]);
        end

        // Restart from DONE holding err_count=2, then a clean run.
        do_start("restart");
        for (int i = 0; i < N_VEC; i++) xfer(X_W'(i), fq(X_W'(i)), 1'b0);
        final_check(vecs[0]);

        // exp_we and start pulsed during RUN before x=2 arrives: both must be ignored.
        do_start("ignore");
        for (int i = 0; i < N_VEC; i++) xfer(X_W'(i), fq(X_W'(i)), i == 1);
        v = vecs[0];
        v.name = "ignore";
        final_check(v);

        // Reset after the 7th transfer clears everything, including the table.
        do_start("midrst");
        for (int i = 0; i < 7; i++) xfer(X_W'(i), fq(X_W'(i)), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_all_zero("midrst");
        for (int i = 0; i < N_VEC; i++) mtable[i] = '0;
        model_clear_run();
        @(negedge clk) rst_n = 1'b1;

        do_start("zero");
        for (int i = 0; i < N_VEC; i++) xfer(X_W'(i), 2'b00, 1'b0);
        v = vecs[0];
        v.name = "zero";
        final_check(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
